// File: rtl/alu_op_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: operation codes,
// ALUOp / funct7 encodings and the sequencer state encoding.
// The RV32M path is enabled by defining ALU_OP_SEQ_MULDIV_EN.
package alu_op_seq_pkg;

    // Extended operation code presented to the execute stage.
    typedef enum logic [4:0] {
        OP_AND    = 5'd0,
        OP_OR     = 5'd1,
        OP_ADD    = 5'd2,
        OP_XOR    = 5'd3,
        OP_SLL    = 5'd4,
        OP_SRL    = 5'd5,
        OP_SUB    = 5'd6,
        OP_SRA    = 5'd7,
        OP_SLT    = 5'd8,
        OP_SLTU   = 5'd9,
        OP_BEQ    = 5'd10,
        OP_BNE    = 5'd11,
        OP_BLT    = 5'd12,
        OP_BGE    = 5'd13,
        OP_BLTU   = 5'd14,
        OP_BGEU   = 5'd15,
        OP_PASS_B = 5'd16,
        OP_JAL    = 5'd17,
        OP_MUL    = 5'd18,
        OP_MULH   = 5'd19,
        OP_MULHSU = 5'd20,
        OP_MULHU  = 5'd21,
        OP_DIV    = 5'd22,
        OP_DIVU   = 5'd23,
        OP_REM    = 5'd24,
        OP_REMU   = 5'd25
    } alu_operation_e;

    // ALUOp field from the main decoder.
    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_ARITH = 2'b10;
    localparam logic [1:0] ALUOP_JMP   = 2'b11;

    // funct7 patterns that select base, alternate (SUB/SRA) and RV32M ops.
    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

    // RV32M ops are laid out contiguously from MUL in funct3 order.
    function automatic alu_operation_e muldiv_op(input logic [2:0] f3);
        logic [4:0] base;
        base = OP_MUL;
        return alu_operation_e'(base + {2'b00, f3});
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of (alu_op, funct7, funct3, r_type) into an
// extended operation code. Undecodable requests collapse to ADD with
// illegal set. RV32M decode exists only when ALU_OP_SEQ_MULDIV_EN is
// defined; otherwise funct7=0000001 on an R-type is illegal.
module alu_op_decode
    import alu_op_seq_pkg::*;
(
    input  logic [1:0]     alu_op,
    input  logic [6:0]     funct7,
    input  logic [2:0]     funct3,
    input  logic           r_type,
    output alu_operation_e operation,
    output logic           illegal,
    output logic           is_muldiv,
    output logic           is_div
);

    logic f7_base;
    logic f7_alt;
    logic f7_md;
    logic rt_bad;

    assign f7_base = (funct7 == FUNCT7_BASE);
    assign f7_alt  = (funct7 == FUNCT7_ALT);
    assign f7_md   = (funct7 == FUNCT7_MULDIV);
    // Register-register ops other than ADD/SUB and SRL/SRA only accept funct7=0.
    assign rt_bad  = r_type && !f7_base;

    // Map the request onto an operation code; anything undecodable becomes ADD.
    always_comb begin
        operation = OP_ADD;
        illegal   = 1'b0;
        is_muldiv = 1'b0;
        is_div    = 1'b0;
        case (alu_op)
            ALUOP_MEM: operation = OP_ADD;
            ALUOP_JMP: operation = OP_JAL;
            ALUOP_BR: begin
                case (funct3)
                    3'b000:  operation = OP_BEQ;
                    3'b001:  operation = OP_BNE;
                    3'b100:  operation = OP_BLT;
                    3'b101:  operation = OP_BGE;
                    3'b110:  operation = OP_BLTU;
                    3'b111:  operation = OP_BGEU;
                    default: illegal   = 1'b1;
                endcase
            end
            ALUOP_ARITH: begin
                if (r_type && f7_md) begin
`ifdef ALU_OP_SEQ_MULDIV_EN
                    operation = muldiv_op(funct3);
                    is_muldiv = 1'b1;
                    is_div    = funct3[2];
`else
                    illegal   = 1'b1;
`endif
                end else begin
                    case (funct3)
                        3'b000: begin
                            // funct7 is immediate data on ADDI, so it only matters for R-type.
                            if (r_type && f7_alt)
                                operation = OP_SUB;
                            else begin
                                operation = OP_ADD;
                                illegal   = rt_bad;
                            end
                        end
                        3'b001: begin
                            operation = OP_SLL;
                            illegal   = !f7_base;
                        end
                        3'b101: begin
                            if (f7_base)
                                operation = OP_SRL;
                            else if (f7_alt)
                                operation = OP_SRA;
                            else
                                illegal = 1'b1;
                        end
                        3'b010: begin
                            operation = OP_SLT;
                            illegal   = rt_bad;
                        end
                        3'b011: begin
                            operation = OP_SLTU;
                            illegal   = rt_bad;
                        end
                        3'b100: begin
                            operation = OP_XOR;
                            illegal   = rt_bad;
                        end
                        3'b110: begin
                            operation = OP_OR;
                            illegal   = rt_bad;
                        end
                        default: begin
                            operation = OP_AND;
                            illegal   = rt_bad;
                        end
                    endcase
                end
            end
            default: operation = OP_ADD;
        endcase
        // Illegal requests always present ADD and never take the multi-cycle path.
        if (illegal) begin
            operation = OP_ADD;
            is_muldiv = 1'b0;
            is_div    = 1'b0;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered ALU operation sequencer between ID/EX and the ALU / mul-div
// unit. Decodes a request, holds it in a one-entry output register with
// valid/ready handshakes, and (with ALU_OP_SEQ_MULDIV_EN defined) stalls
// the issuing stage for MUL_LAT / DIV_LAT cycles on RV32M operations,
// pulsing md_start on issue and md_abort when a flush kills one in flight.
// Without the macro the block is just decode plus output register.
module alu_op_sequencer
    import alu_op_seq_pkg::*;
#(
    parameter int OP_W    = 5,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 33
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic            r_type,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] operation,
    output logic            illegal,
    output logic            md_start,
    output logic            md_abort,
    output logic            busy
);

    alu_operation_e dec_op;
    logic [4:0]     dec_code;
    logic           dec_illegal;
    logic           dec_is_md;
    logic           dec_is_div;
    logic           accept;

    alu_op_decode u_decode (
        .alu_op    (alu_op),
        .funct7    (funct7),
        .funct3    (funct3),
        .r_type    (r_type),
        .operation (dec_op),
        .illegal   (dec_illegal),
        .is_muldiv (dec_is_md),
        .is_div    (dec_is_div)
    );

    assign dec_code = dec_op;
    assign accept   = in_valid && in_ready;

`ifdef ALU_OP_SEQ_MULDIV_EN

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_BUSY  = ST_BUSY;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] lat_m1;
    logic [4:0]       md_code_p1;

    assign lat_m1 = dec_is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

    // Only IDLE accepts; a flush cycle or a held, unconsumed result blocks it.
    assign in_ready = rst_n && !flush && (state == S_IDLE) && (!out_valid || out_ready);
    assign busy     = (state == S_BUSY);

    // Stage p0 -> p1: remember which M op is in flight until its result is due.
    always_ff @(posedge clk) begin
        if (accept && dec_is_md)
            md_code_p1 <= dec_code;
    end

    // Sequencer FSM, latency counter, output register and mul/div pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            count     <= '0;
            out_valid <= 1'b0;
            operation <= '0;
            illegal   <= 1'b0;
            md_start  <= 1'b0;
            md_abort  <= 1'b0;
        end else begin
            md_start <= 1'b0;
            md_abort <= 1'b0;
            if (flush) begin
                // Kills everything; an M op still counting must be aborted downstream.
                state     <= S_IDLE;
                count     <= '0;
                out_valid <= 1'b0;
                md_abort  <= (state == S_BUSY);
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept && dec_is_md) begin
                            md_start <= 1'b1;
                            if (lat_m1 == '0) begin
                                // Single-cycle unit: result is due right away.
                                state     <= S_DRAIN;
                                out_valid <= 1'b1;
                                operation <= OP_W'(dec_code);
                                illegal   <= 1'b0;
                            end else begin
                                state     <= S_BUSY;
                                count     <= lat_m1;
                                out_valid <= 1'b0;
                            end
                        end else if (accept) begin
                            out_valid <= 1'b1;
                            operation <= OP_W'(dec_code);
                            illegal   <= dec_illegal;
                        end else if (out_ready) begin
                            out_valid <= 1'b0;
                        end
                    end
                    S_BUSY: begin
                        if (count == '0) begin
                            state     <= S_DRAIN;
                            out_valid <= 1'b1;
                            operation <= OP_W'(md_code_p1);
                            illegal   <= 1'b0;
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        if (out_ready) begin
                            state     <= S_IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`else

    // Latency parameters and M-op decode flags have no consumer in this build.
    localparam int unused_lat = MUL_LAT + DIV_LAT;
    logic unused_md;
    assign unused_md = dec_is_md ^ dec_is_div;

    assign in_ready = rst_n && !flush && (!out_valid || out_ready);
    assign busy     = 1'b0;
    assign md_start = 1'b0;
    assign md_abort = 1'b0;

    // One-entry output register; holds while out_valid && !out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            operation <= '0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            operation <= OP_W'(dec_code);
            illegal   <= dec_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    localparam int OP_W    = 5;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 33;
    localparam int N_RAND  = 1500;
`ifdef ALU_OP_SEQ_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic            r_type;
    logic            out_valid;
    logic            out_ready;
    logic [OP_W-1:0] operation;
    logic            illegal;
    logic            md_start;
    logic            md_abort;
    logic            busy;

    always #5 clk = ~clk;

    alu_op_sequencer #(.OP_W(OP_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct7    (funct7),
        .funct3    (funct3),
        .r_type    (r_type),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .operation (operation),
        .illegal   (illegal),
        .md_start  (md_start),
        .md_abort  (md_abort),
        .busy      (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input logic v, input logic [1:0] a, input logic [6:0] f7,
                         input logic [2:0] f3, input logic r);
        in_valid = v;
        alu_op   = a;
        funct7   = f7;
        funct3   = f3;
        r_type   = r;
    endtask

    // Reference decode written from the operation tables.
    function automatic void ref_decode(input logic [1:0] a, input logic [6:0] f7,
                                       input logic [2:0] f3, input logic r,
                                       output int op, output bit ill,
                                       output bit is_m, output int lat);
        int br_tab[8];
        int ar_tab[8];
        bit shift;
        br_tab = '{10, 11, -1, -1, 12, 13, 14, 15};
        ar_tab = '{2, 4, 8, 9, 3, 5, 1, 0};
        shift  = (f3 == 3'd1) || (f3 == 3'd5);
        op = 2; ill = 1'b0; is_m = 1'b0; lat = 1;
        case (a)
            2'd0: op = 2;
            2'd3: op = 17;
            2'd1: begin op = br_tab[f3]; ill = (op < 0); end
            default: begin
                if (r && f7 == 7'h01) begin
                    if (MD_EN) begin
                        op = 18 + int'(f3);
                        is_m = 1'b1;
                        lat = (f3 >= 3'd4) ? DIV_LAT : MUL_LAT;
                    end else ill = 1'b1;
                end else if (!(r || shift) || f7 == 7'h00) op = ar_tab[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) op = 6;
                else if (f7 == 7'h20 && f3 == 3'd5) op = 7;
                else ill = 1'b1;
            end
        endcase
        if (ill) op = 2;
    endfunction

    typedef struct {
        logic [1:0] a;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       r;
        int         op;
        int         ill;
    } vec_t;

    typedef struct {
        int op;
        bit ill;
        bit drain;
    } res_t;

    vec_t vt[$];
    res_t q[$];
    bit   m_pend, e_start, e_abort, exp_ir, r_ill, r_m;
    int   m_done, ecnt, r_op, r_lat;
    res_t m_res;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // single-cycle decode table, applied back to back with out_ready=1
        vt.push_back('{2'b10, 7'h20, 3'b000, 1'b1, 6, 0});   // SUB
        vt.push_back('{2'b10, 7'h20, 3'b000, 1'b0, 2, 0});   // ADDI
        vt.push_back('{2'b01, 7'h00, 3'b000, 1'b0, 10, 0});  // BEQ
        vt.push_back('{2'b01, 7'h00, 3'b111, 1'b0, 15, 0});  // BGEU
        vt.push_back('{2'b10, 7'h20, 3'b101, 1'b1, 7, 0});   // SRA
        vt.push_back('{2'b10, 7'h00, 3'b111, 1'b1, 0, 0});   // AND
        vt.push_back('{2'b00, 7'h00, 3'b010, 1'b0, 2, 0});   // LW
        vt.push_back('{2'b11, 7'h00, 3'b000, 1'b0, 17, 0});  // JAL
        vt.push_back('{2'b01, 7'h00, 3'b001, 1'b0, 11, 0});  // BNE
        vt.push_back('{2'b01, 7'h00, 3'b100, 1'b0, 12, 0});  // BLT
        vt.push_back('{2'b01, 7'h00, 3'b010, 1'b0, 2, 1});   // branch f3=010
        vt.push_back('{2'b01, 7'h00, 3'b011, 1'b0, 2, 1});   // branch f3=011
        vt.push_back('{2'b10, 7'h00, 3'b010, 1'b1, 8, 0});   // SLT
        vt.push_back('{2'b10, 7'h00, 3'b011, 1'b0, 9, 0});   // SLTIU
        vt.push_back('{2'b10, 7'h00, 3'b101, 1'b1, 5, 0});   // SRL
        vt.push_back('{2'b10, 7'h00, 3'b001, 1'b1, 4, 0});   // SLL
        vt.push_back('{2'b10, 7'h20, 3'b001, 1'b1, 2, 1});   // SLL with alt funct7
        vt.push_back('{2'b10, 7'h20, 3'b110, 1'b1, 2, 1});   // OR with alt funct7
        vt.push_back('{2'b10, 7'h55, 3'b110, 1'b0, 1, 0});   // ORI, funct7 is immediate
        vt.push_back('{2'b10, 7'h01, 3'b101, 1'b0, 2, 1});   // SRLI with funct7=1
        vt.push_back('{2'b10, 7'h02, 3'b111, 1'b1, 2, 1});   // AND with bad funct7

        // reset
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 2'b00, 7'h00, 3'b000, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_operation", 32'(operation), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_md_start", 32'(md_start), 0);
        chk("rst_md_abort", 32'(md_abort), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_in_ready", 32'(in_ready), 1);

        // table-driven decode stream
        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            drive(1'b1, vt[i].a, vt[i].f7, vt[i].f3, vt[i].r);
            out_ready = 1'b1;
            #1 chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 1);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 1);
            chk($sformatf("tbl%0d_operation", i), 32'(operation), 32'(vt[i].op));
            chk($sformatf("tbl%0d_illegal", i), 32'(illegal), 32'(vt[i].ill));
        end
        @(negedge clk);
        drive(1'b0, 2'b00, 7'h00, 3'b000, 1'b0);
        @(negedge clk);
        chk("drain_out_valid", 32'(out_valid), 0);

        // output held under back-pressure
        drive(1'b1, 2'b10, 7'h00, 3'b100, 1'b1);  // XOR
        out_ready = 1'b0;
        @(negedge clk);
        drive(1'b1, 2'b10, 7'h00, 3'b000, 1'b1);  // ADD waiting behind it
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("hold_out_valid", 32'(out_valid), 1);
            chk("hold_operation", 32'(operation), 3);
            chk("hold_in_ready", 32'(in_ready), 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1 chk("release_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        chk("release_out_valid", 32'(out_valid), 0);

        // flush clears a held result and blocks accept in its own cycle
        drive(1'b1, 2'b10, 7'h00, 3'b100, 1'b1);
        out_ready = 1'b0;
        @(negedge clk);
        drive(1'b1, 2'b10, 7'h00, 3'b111, 1'b1);
        flush = 1'b1;
        #1 chk("flush_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 0);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

`ifdef ALU_OP_SEQ_MULDIV_EN
        // MUL: start pulse, stall, result after MUL_LAT edges
        drive(1'b1, 2'b10, 7'h01, 3'b000, 1'b1);
        #1 chk("mul_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        drive(1'b1, 2'b10, 7'h00, 3'b000, 1'b1);
        for (int k = 0; k < MUL_LAT; k++) begin
            #1;
            chk($sformatf("mul_c%0d_md_start", k), 32'(md_start), (k == 0) ? 1 : 0);
            chk($sformatf("mul_c%0d_busy", k), 32'(busy), 1);
            chk($sformatf("mul_c%0d_out_valid", k), 32'(out_valid), 0);
            chk($sformatf("mul_c%0d_in_ready", k), 32'(in_ready), 0);
            @(negedge clk);
        end
        #1;
        chk("mul_res_out_valid", 32'(out_valid), 1);
        chk("mul_res_operation", 32'(operation), 18);
        chk("mul_res_illegal", 32'(illegal), 0);
        chk("mul_res_busy", 32'(busy), 0);
        chk("mul_res_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        chk("mul_after_out_valid", 32'(out_valid), 0);
        chk("mul_after_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        chk("mul_next_out_valid", 32'(out_valid), 1);
        chk("mul_next_operation", 32'(operation), 2);
        in_valid = 1'b0;
        @(negedge clk);

        // DIVU aborted by a flush 5 edges after accept
        drive(1'b1, 2'b10, 7'h01, 3'b101, 1'b1);
        #1 chk("divu_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("divu_md_start", 32'(md_start), 1);
        chk("divu_busy", 32'(busy), 1);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        drive(1'b1, 2'b10, 7'h00, 3'b000, 1'b1);
        #1 chk("divu_flush_in_ready", 32'(in_ready), 0);
        chk("divu_flush_busy", 32'(busy), 1);
        @(negedge clk);
        chk("divu_md_abort", 32'(md_abort), 1);
        chk("divu_abort_busy", 32'(busy), 0);
        chk("divu_abort_out_valid", 32'(out_valid), 0);
        flush = 1'b0;
        #1 chk("divu_next_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        chk("divu_abort_once", 32'(md_abort), 0);
        chk("divu_next_out_valid", 32'(out_valid), 1);
        chk("divu_next_operation", 32'(operation), 2);
        in_valid = 1'b0;
        @(negedge clk);
`else
        // without the M extension, funct7=0000001 is just illegal
        drive(1'b1, 2'b10, 7'h01, 3'b000, 1'b1);
        #1 chk("nomd_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("nomd_out_valid", 32'(out_valid), 1);
        chk("nomd_illegal", 32'(illegal), 1);
        chk("nomd_operation", 32'(operation), 2);
        chk("nomd_md_start", 32'(md_start), 0);
        chk("nomd_busy", 32'(busy), 0);
        @(negedge clk);
`endif

        // randomized traffic against the transaction-level model
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        q.delete();
        m_pend = 1'b0; e_start = 1'b0; e_abort = 1'b0; ecnt = 0; m_done = 0;
        for (int c = 0; c < N_RAND; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 70);
            flush     = ($urandom_range(0, 99) < 3);
            alu_op    = 2'($urandom_range(0, 3));
            funct3    = 3'($urandom_range(0, 7));
            r_type    = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: funct7 = 7'h00;
                1: funct7 = 7'h20;
                2: funct7 = 7'h01;
                default: funct7 = 7'($urandom);
            endcase
            exp_ir = !flush && !m_pend && (q.size() == 0 || (out_ready && !q[0].drain));
            #1;
            chk("rnd_out_valid", 32'(out_valid), (q.size() > 0) ? 1 : 0);
            chk("rnd_in_ready", 32'(in_ready), 32'(exp_ir));
            chk("rnd_busy", 32'(busy), 32'(m_pend));
            chk("rnd_md_start", 32'(md_start), 32'(e_start));
            chk("rnd_md_abort", 32'(md_abort), 32'(e_abort));
            if (q.size() > 0) begin
                chk("rnd_operation", 32'(operation), 32'(q[0].op));
                chk("rnd_illegal", 32'(illegal), 32'(q[0].ill));
            end
            @(posedge clk);
            ecnt++;
            e_start = 1'b0;
            e_abort = 1'b0;
            if (flush) begin
                e_abort = m_pend;
                m_pend = 1'b0;
                q.delete();
            end else begin
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (m_pend && ecnt == m_done) begin
                    q.push_back(m_res);
                    m_pend = 1'b0;
                end else if (in_valid && exp_ir) begin
                    ref_decode(alu_op, funct7, funct3, r_type, r_op, r_ill, r_m, r_lat);
                    if (r_m) begin
                        e_start = 1'b1;
                        m_res = '{r_op, 1'b0, 1'b1};
                        if (r_lat == 1) q.push_back(m_res);
                        else begin
                            m_pend = 1'b1;
                            m_done = ecnt + r_lat;
                        end
                    end else begin
                        q.push_back('{r_op, r_ill, 1'b0});
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
